uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It latches a parallel byte, serializes it LSB-first, computes the parity bit, and drives the 2-bit select of the TX output mux. The select encoding is: 00 = line high (idle/stop), 01 = start bit (0), 11 = serial data, 10 = parity. The block runs on the bit-rate clock: one UART bit is sent per CLK cycle.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5-9)

Ports:
CLK  input  1  bit-rate clock; all state updates on the rising edge
RST  input  1  asynchronous, active-low reset
P_DATA  input  DATA_WIDTH  parallel data to transmit
Data_Valid  input  1  request to send P_DATA; sampled only in IDLE
PAR_EN  input  1  1 = insert a parity bit; sampled together with P_DATA
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled together with P_DATA
mux_sel  output  2  TX output mux select (encoding above)
S_DATA  output  1  current serial data bit, to the mux data input
par_bit  output  1  parity bit of the latched frame, to the mux parity input
busy  output  1  high while a frame is in flight

Behaviour:
- Reset (RST=0, asynchronous; also in effect mid-frame):
  - state = IDLE; shift register, bit counter, latched PAR_EN/PAR_TYP and par_bit all cleared.
  - Outputs: mux_sel=00, S_DATA=0, par_bit=0, busy=0.
  - A frame in progress is abandoned. The line returns high immediately and nothing is resumed after reset release.
- States: IDLE, START, DATA, PARITY, STOP. mux_sel is a pure decode of the registered state:
  - IDLE = 00, START = 01, DATA = 11, PARITY = 10, STOP = 00.
- IDLE:
  - If Data_Valid=1 at a CLK edge: latch P_DATA into the shift register; latch PAR_EN and PAR_TYP; register par_bit = (^P_DATA) XOR PAR_TYP; clear the bit counter; go to START.
  - Otherwise stay in IDLE.
- START: one cycle; go to DATA.
- DATA: DATA_WIDTH cycles.
  - S_DATA = shift_reg[0]. The shift register shifts right by one at each DATA-cycle edge; the bit counter increments.
  - When counter = DATA_WIDTH-1, leave DATA: go to PARITY if the latched PAR_EN=1, else STOP.
- PARITY: one cycle; go to STOP.
- STOP: one cycle; go to IDLE.
- busy:
  - Registered; 1 in START, DATA, PARITY and STOP; 0 in IDLE.
  - Rises on the same edge that accepts Data_Valid.
- Latency: the start bit appears on mux_sel in the cycle after the accepting edge.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles.
- Data_Valid pulses in any non-IDLE state are ignored and dropped; there is no queueing.
- Changes on P_DATA, PAR_EN or PAR_TYP during a frame have no effect on that frame.
- Back-to-back: with Data_Valid held high, the next frame is accepted in the IDLE cycle after STOP. This gives exactly one idle-high cycle between the stop bit and the next start bit; the minimum frame period is frame length + 1.
- S_DATA outside DATA state is don't-care but must be deterministic, equal to shift_reg[0].
- par_bit is held stable from acceptance until the next acceptance or reset.

Test Plan:
1. Reset, then P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX line (mux output) = 0,1,0,1,0,0,1,0,1,0(par),1(stop) over 11 cycles. busy is high for exactly those 11 cycles. mux_sel sequence is 01, 11×8, 10, 00.
2. Same data with PAR_TYP=1 -> parity cycle = 1; everything else identical.
3. P_DATA=0x0F, PAR_EN=0 -> 10-cycle frame 0,1,1,1,1,0,0,0,0,1; no 10 select ever appears; busy high for 10 cycles.
4. Accept 0x3C, then pulse Data_Valid with P_DATA=0xFF in cycle 4 of DATA -> the pulse is ignored and the frame still carries 0x3C. Returns to IDLE with busy=0 and no second frame.
5. Data_Valid held high with P_DATA=0x55 then 0xAA (PAR_EN=1) -> two complete frames with exactly one idle cycle (mux_sel=00, busy=0) between them.
6. Assert RST low asynchronously mid-DATA (between edges) -> mux_sel=00 and busy=0 immediately. After release the controller stays in IDLE until a new Data_Valid, then sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: bundle between the UART TX frame sequencer and its user/mux.
// Ports (master = frame source, slave = sequencer):
//   P_DATA, Data_Valid, PAR_EN, PAR_TYP : request side, driven by the master
//   mux_sel, S_DATA, par_bit, busy      : mux controls and status, driven by the slave
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [1:0]            mux_sel;
    logic                  S_DATA;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  mux_sel, S_DATA, par_bit, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output mux_sel, S_DATA, par_bit, busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX frame sequencer, one bit per CLK, LSB-first, optional parity.
// Ports:
//   CLK : bit-rate clock
//   RST : asynchronous active-low reset
//   bus : uart_tx_ctrl_if slave (request in, mux_sel/S_DATA/par_bit/busy out)
// mux_sel encoding: 00 line high, 01 start, 11 serial data, 10 parity.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_ctrl_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            busy_q    <= busy_d;
        end
    end

    // PAR_TYP only matters at acceptance, where it is folded into par_bit,
    // so it needs no register of its own.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        case (state_q)
            IDLE: if (bus.Data_Valid) begin
                shift_d   = bus.P_DATA;
                cnt_d     = '0;
                par_en_d  = bus.PAR_EN;
                par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                state_d   = START;
            end
            START:  state_d = DATA;
            DATA: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_WIDTH - 1))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.mux_sel = (state_q == START)  ? 2'b01 :
                         (state_q == DATA)   ? 2'b11 :
                         (state_q == PARITY) ? 2'b10 : 2'b00;
    assign bus.S_DATA  = shift_q[0];
    assign bus.par_bit = par_bit_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl (DATA_WIDTH = 8).
module tb_uart_tx_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Level seen on the TX pin through the output mux.
    function automatic logic tx_line();
        return (bus.mux_sel == 2'b00) ? 1'b1 :
               (bus.mux_sel == 2'b01) ? 1'b0 :
               (bus.mux_sel == 2'b11) ? bus.S_DATA : bus.par_bit;
    endfunction

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input bit hold);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        if (!hold) bus.Data_Valid = 1'b0;
    endtask

    // Called at the negedge right after the accepting edge. exp_line lists the
    // TX levels in time order from bit len-1 down to bit 0.
    task automatic frame(input string tag, input logic [10:0] exp_line, input int len,
                         input logic pe, input logic exp_par, input int inj);
        logic [1:0] es;
        for (int i = 0; i < len; i++) begin
            es = (i == 0) ? 2'b01 : (i <= 8) ? 2'b11 : (pe && i == 9) ? 2'b10 : 2'b00;
            check($sformatf("%s line[%0d]", tag, i), tx_line(), exp_line[len-1-i]);
            check($sformatf("%s sel[%0d]", tag, i), bus.mux_sel, es);
            check($sformatf("%s busy[%0d]", tag, i), bus.busy, 1);
            if (inj >= 0 && i == inj) begin
                bus.P_DATA     = 8'hFF;
                bus.Data_Valid = 1'b1;
            end else if (inj >= 0 && i == inj + 1) begin
                bus.Data_Valid = 1'b0;
            end
            @(negedge CLK);
        end
        check($sformatf("%s idle sel", tag), bus.mux_sel, 2'b00);
        check($sformatf("%s idle busy", tag), bus.busy, 0);
        check($sformatf("%s par_bit", tag), bus.par_bit, exp_par);
    endtask

    initial begin
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst sel", bus.mux_sel, 2'b00);
        check("rst busy", bus.busy, 0);
        check("rst par_bit", bus.par_bit, 0);
        check("rst sdata", bus.S_DATA, 0);
        RST = 1'b1;
        @(negedge CLK);
        check("post-rst busy", bus.busy, 0);

        // 0xA5 even parity
        send(8'hA5, 1'b1, 1'b0, 1'b0);
        frame("a5_even", 11'b0_10100101_0_1, 11, 1'b1, 1'b0, -1);
        // 0xA5 odd parity
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        frame("a5_odd", 11'b0_10100101_1_1, 11, 1'b1, 1'b1, -1);
        // 0x0F without parity
        send(8'h0F, 1'b0, 1'b0, 1'b0);
        frame("0f_nopar", 11'b0_0_11110000_1, 10, 1'b0, 1'b0, -1);

        // 0x3C with a dropped Data_Valid of 0xFF in the 4th DATA cycle
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        frame("3c_inj", 11'b0_00111100_0_1, 11, 1'b1, 1'b0, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("3c_after busy[%0d]", i), bus.busy, 0);
            check($sformatf("3c_after sel[%0d]", i), bus.mux_sel, 2'b00);
        end

        // back-to-back with Data_Valid held high
        send(8'h55, 1'b1, 1'b0, 1'b1);
        bus.P_DATA = 8'hAA;
        frame("b2b_55", 11'b0_10101010_0_1, 11, 1'b1, 1'b0, -1);
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        frame("b2b_aa", 11'b0_01010101_0_1, 11, 1'b1, 1'b0, -1);

        // asynchronous reset in the middle of DATA
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge CLK);
        check("pre-rst sel", bus.mux_sel, 2'b11);
        #2 RST = 1'b0;
        #1;
        check("async sel", bus.mux_sel, 2'b00);
        check("async busy", bus.busy, 0);
        check("async par_bit", bus.par_bit, 0);
        check("async line", tx_line(), 1);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("rel busy[%0d]", i), bus.busy, 0);
            check($sformatf("rel sel[%0d]", i), bus.mux_sel, 2'b00);
        end
        send(8'h81, 1'b1, 1'b1, 1'b0);
        frame("81_odd", 11'b0_10000001_1_1, 11, 1'b1, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
